ysyx_22050133_axi_arbiter: RTL and testbench

//  Two-requester arbiter in front of ysyx_22050133_axi_master's rw_* port. Shares the port between IFU
//  (read-only fetch) and LSU (load/store). One transaction is outstanding at a time; the granted

---
 rtl/ysyx_22050133_axi_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_ysyx_22050133_axi_arbiter.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_axi_arbiter.sv
// Two-requester arbiter (IFU fetch / LSU load-store) in front of the AXI master's rw_* port.
// One transaction is outstanding at a time. The granted port keeps the master until its last
// data beat completes and the master reports idle again through m_addr_ready_i.
// Optional build macro: YSYX_22050133_ARB_RR_EN selects round-robin tie-breaking. When it is
// left undefined, the LSU always wins over the IFU.
module ysyx_22050133_axi_arbiter #(
   parameter int RW_DATA_WIDTH = 64,
   parameter int RW_ADDR_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   // IFU: read-only fetch port
   input  logic                     if_addr_valid_i,
   output logic                     if_addr_ready_o,
   input  logic [RW_ADDR_WIDTH-1:0] if_addr_i,
   input  logic [7:0]               if_len_i,
   input  logic [2:0]               if_size_i,
   output logic                     if_r_valid_o,
   input  logic                     if_r_ready_i,
   output logic [RW_DATA_WIDTH-1:0] if_r_data_o,
   // LSU: load/store port
   input  logic                     ls_addr_valid_i,
   output logic                     ls_addr_ready_o,
   input  logic [RW_ADDR_WIDTH-1:0] ls_addr_i,
   input  logic                     ls_we_i,
   input  logic [7:0]               ls_len_i,
   input  logic [2:0]               ls_size_i,
   input  logic                     ls_w_valid_i,
   output logic                     ls_w_ready_o,
   input  logic [RW_DATA_WIDTH-1:0] ls_w_data_i,
   output logic                     ls_r_valid_o,
   input  logic                     ls_r_ready_i,
   output logic [RW_DATA_WIDTH-1:0] ls_r_data_o,
   // Shared master rw_* port
   output logic                     m_addr_valid_o,
   input  logic                     m_addr_ready_i,
   output logic [RW_ADDR_WIDTH-1:0] m_addr_o,
   output logic                     m_we_o,
   output logic [7:0]               m_len_o,
   output logic [2:0]               m_size_o,
   output logic [1:0]               m_burst_o,
   output logic                     m_if_o,
   output logic                     m_w_valid_o,
   input  logic                     m_w_ready_i,
   output logic [RW_DATA_WIDTH-1:0] m_w_data_o,
   input  logic                     m_r_valid_i,
   output logic                     m_r_ready_o,
   input  logic [RW_DATA_WIDTH-1:0] m_r_data_i
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_RDATA,
      ST_WDATA,
      ST_DRAIN
   } state_t;

   typedef enum logic {
      GNT_IFU = 1'b0,
      GNT_LSU = 1'b1
   } grant_t;

   localparam logic [1:0] BURST_INCR = 2'b01;

   state_t     state;
   state_t     state_nxt;
   grant_t     grant;
   grant_t     pick;
   logic [7:0] cnt;
   logic       req_any;
   logic       start;
   logic       is_ifu;
   logic       r_ready_sel;
   logic       r_beat;
   logic       w_beat;

   assign req_any = if_addr_valid_i | ls_addr_valid_i;
   assign start   = (state == ST_IDLE) & req_any;
   assign is_ifu  = (grant == GNT_IFU);

   // The read-ready seen by the master comes from whichever port owns the current burst.
   assign r_ready_sel = is_ifu ? if_r_ready_i : ls_r_ready_i;
   assign r_beat      = (state == ST_RDATA) & m_r_valid_i & r_ready_sel;
   assign w_beat      = (state == ST_WDATA) & ls_w_valid_i & m_w_ready_i;

`ifdef YSYX_22050133_ARB_RR_EN
   grant_t last;

   // Remember which port won the most recent arbitration, for round-robin tie-breaking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= GNT_IFU;
      end else if (start) begin
         last <= pick;
      end
   end
`endif

   // Arbitration: a lone requester always wins; on a tie the build option decides.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      pick = GNT_LSU;
      if (if_addr_valid_i && !ls_addr_valid_i) begin
         pick = GNT_IFU;
      end
`ifdef YSYX_22050133_ARB_RR_EN
      else if (if_addr_valid_i && ls_addr_valid_i && (last == GNT_LSU)) begin
         pick = GNT_IFU;
      end
`endif
   end

   // State, grant and beat-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments, so every register samples the values present before the edge.
      if (rst) begin
         state <= ST_IDLE;
         grant <= GNT_LSU;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         if (start) begin
            grant <= pick;
            cnt   <= (pick == GNT_IFU) ? if_len_i : ls_len_i;
         end else if ((r_beat || w_beat) && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
         end
      end
   end

   // Request fields and data buses follow the grant. Only the valid and ready strobes are gated by state.
   assign m_addr_o    = is_ifu ? if_addr_i : ls_addr_i;
   assign m_len_o     = is_ifu ? if_len_i : ls_len_i;
   assign m_size_o    = is_ifu ? if_size_i : ls_size_i;
   assign m_we_o      = ~is_ifu & ls_we_i;
   assign m_burst_o   = BURST_INCR;
   assign m_if_o      = is_ifu;
   assign m_w_data_o  = ls_w_data_i;
   assign if_r_data_o = m_r_data_i;
   assign ls_r_data_o = m_r_data_i;

   // Next-state logic and handshake routing between the granted port and the master.
   always_comb begin
      state_nxt       = state;
      m_addr_valid_o  = 1'b0;
      if_addr_ready_o = 1'b0;
      ls_addr_ready_o = 1'b0;
      if_r_valid_o    = 1'b0;
      ls_r_valid_o    = 1'b0;
      m_r_ready_o     = 1'b0;
      m_w_valid_o     = 1'b0;
      ls_w_ready_o    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (req_any) begin
               state_nxt = ST_ADDR;
            end
         end

         ST_ADDR: begin
            m_addr_valid_o = 1'b1;
            if (is_ifu) begin
               if_addr_ready_o = m_addr_ready_i;
            end else begin
               ls_addr_ready_o = m_addr_ready_i;
            end
            if (m_addr_ready_i) begin
               state_nxt = m_we_o ? ST_WDATA : ST_RDATA;
            end
         end

         ST_RDATA: begin
            m_r_ready_o = r_ready_sel;
            if (is_ifu) begin
               if_r_valid_o = m_r_valid_i;
            end else begin
               ls_r_valid_o = m_r_valid_i;
            end
            if (r_beat && (cnt == 8'd0)) begin
               state_nxt = ST_DRAIN;
            end
         end

         ST_WDATA: begin
            m_w_valid_o  = ls_w_valid_i;
            ls_w_ready_o = m_w_ready_i;
            if (w_beat && (cnt == 8'd0)) begin
               state_nxt = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // The master raises its address ready only after it returns to idle
            // (write response taken), so it doubles as the end-of-transaction flag.
            if (m_addr_ready_i) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_22050133_axi_arbiter.sv
// Self-checking bench for ysyx_22050133_axi_arbiter. The bench plays the master and both
// requesters. Expected beats are queued when they are driven and popped when the DUT hands them
// out. Expectations follow YSYX_22050133_ARB_RR_EN when that macro is defined.
module tb_ysyx_22050133_axi_arbiter;

   localparam int DW = 64;
   localparam int AW = 32;

   logic          clk;
   logic          rst;
   logic          if_addr_valid_i;
   logic          if_addr_ready_o;
   logic [AW-1:0] if_addr_i;
   logic [7:0]    if_len_i;
   logic [2:0]    if_size_i;
   logic          if_r_valid_o;
   logic          if_r_ready_i;
   logic [DW-1:0] if_r_data_o;
   logic          ls_addr_valid_i;
   logic          ls_addr_ready_o;
   logic [AW-1:0] ls_addr_i;
   logic          ls_we_i;
   logic [7:0]    ls_len_i;
   logic [2:0]    ls_size_i;
   logic          ls_w_valid_i;
   logic          ls_w_ready_o;
   logic [DW-1:0] ls_w_data_i;
   logic          ls_r_valid_o;
   logic          ls_r_ready_i;
   logic [DW-1:0] ls_r_data_o;
   logic          m_addr_valid_o;
   logic          m_addr_ready_i;
   logic [AW-1:0] m_addr_o;
   logic          m_we_o;
   logic [7:0]    m_len_o;
   logic [2:0]    m_size_o;
   logic [1:0]    m_burst_o;
   logic          m_if_o;
   logic          m_w_valid_o;
   logic          m_w_ready_i;
   logic [DW-1:0] m_w_data_o;
   logic          m_r_valid_i;
   logic          m_r_ready_o;
   logic [DW-1:0] m_r_data_i;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] if_q[$];
   logic [DW-1:0] ls_q[$];
   logic [DW-1:0] w_q[$];
   logic [DW-1:0] mon_exp;

   ysyx_22050133_axi_arbiter #(
      .RW_DATA_WIDTH(DW),
      .RW_ADDR_WIDTH(AW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .if_addr_valid_i (if_addr_valid_i),
      .if_addr_ready_o (if_addr_ready_o),
      .if_addr_i       (if_addr_i),
      .if_len_i        (if_len_i),
      .if_size_i       (if_size_i),
      .if_r_valid_o    (if_r_valid_o),
      .if_r_ready_i    (if_r_ready_i),
      .if_r_data_o     (if_r_data_o),
      .ls_addr_valid_i (ls_addr_valid_i),
      .ls_addr_ready_o (ls_addr_ready_o),
      .ls_addr_i       (ls_addr_i),
      .ls_we_i         (ls_we_i),
      .ls_len_i        (ls_len_i),
      .ls_size_i       (ls_size_i),
      .ls_w_valid_i    (ls_w_valid_i),
      .ls_w_ready_o    (ls_w_ready_o),
      .ls_w_data_i     (ls_w_data_i),
      .ls_r_valid_o    (ls_r_valid_o),
      .ls_r_ready_i    (ls_r_ready_i),
      .ls_r_data_o     (ls_r_data_o),
      .m_addr_valid_o  (m_addr_valid_o),
      .m_addr_ready_i  (m_addr_ready_i),
      .m_addr_o        (m_addr_o),
      .m_we_o          (m_we_o),
      .m_len_o         (m_len_o),
      .m_size_o        (m_size_o),
      .m_burst_o       (m_burst_o),
      .m_if_o          (m_if_o),
      .m_w_valid_o     (m_w_valid_o),
      .m_w_ready_i     (m_w_ready_i),
      .m_w_data_o      (m_w_data_o),
      .m_r_valid_i     (m_r_valid_i),
      .m_r_ready_o     (m_r_ready_o),
      .m_r_data_i      (m_r_data_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   // Scoreboard monitor: samples completed handshakes just before each rising edge.
   always @(negedge clk) begin
      #4;
      if (if_r_valid_o && if_r_ready_i) begin
         total++;
         if (if_q.size() == 0) begin
            bad++;
            $display("FAIL if_r_unexpected got=%h want=no_beat", if_r_data_o);
         end else begin
            mon_exp = if_q.pop_front();
            if (if_r_data_o !== mon_exp) begin
               bad++;
               $display("FAIL if_r_data got=%h want=%h", if_r_data_o, mon_exp);
            end
         end
      end
      if (ls_r_valid_o && ls_r_ready_i) begin
         total++;
         if (ls_q.size() == 0) begin
            bad++;
            $display("FAIL ls_r_unexpected got=%h want=no_beat", ls_r_data_o);
         end else begin
            mon_exp = ls_q.pop_front();
            if (ls_r_data_o !== mon_exp) begin
               bad++;
               $display("FAIL ls_r_data got=%h want=%h", ls_r_data_o, mon_exp);
            end
         end
      end
      if (m_w_valid_o && m_w_ready_i) begin
         total++;
         if (w_q.size() == 0) begin
            bad++;
            $display("FAIL m_w_unexpected got=%h want=no_beat", m_w_data_o);
         end else begin
            mon_exp = w_q.pop_front();
            if (m_w_data_o !== mon_exp) begin
               bad++;
               $display("FAIL m_w_data got=%h want=%h", m_w_data_o, mon_exp);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      if_addr_valid_i = 1'b0;
      if_addr_i       = '0;
      if_len_i        = 8'd0;
      if_size_i       = 3'd3;
      if_r_ready_i    = 1'b0;
      ls_addr_valid_i = 1'b0;
      ls_addr_i       = '0;
      ls_we_i         = 1'b0;
      ls_len_i        = 8'd0;
      ls_size_i       = 3'd3;
      ls_w_valid_i    = 1'b0;
      ls_w_data_i     = '0;
      ls_r_ready_i    = 1'b0;
      m_addr_ready_i  = 1'b0;
      m_w_ready_i     = 1'b0;
      m_r_valid_i     = 1'b0;
      m_r_data_i      = '0;
   endtask

   // Serves one transaction as the master. The requester's address request must already be driven.
   // Stray master/requester strobes are held during DRAIN so that any leak becomes an unexpected beat.
   task automatic run_txn(input bit exp_if, input bit exp_we, input logic [AW-1:0] exp_addr,
                          input logic [7:0] exp_len, input logic [DW-1:0] base, input bit toggle,
                          input int drain_wait, input bit keep_req, output int lat);
      int got;
      bit ph;
      logic rdy;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         settle();
         if (m_addr_valid_o === 1'b1) begin
            lat = i;
            break;
         end
      end
      total++;
      if (lat == 0) begin
         bad++;
         $display("FAIL addr_timeout got=no_valid want=m_addr_valid_o");
         return;
      end
      total++;
      if ({m_if_o, m_we_o, m_addr_o, m_len_o, m_size_o, m_burst_o} !==
          {exp_if, exp_we, exp_addr, exp_len, 3'd3, 2'b01}) begin
         bad++;
         $display("FAIL addr_fields got=if%b we%b a%h l%h s%h b%b want=if%b we%b a%h l%h s3 b01",
                  m_if_o, m_we_o, m_addr_o, m_len_o, m_size_o, m_burst_o,
                  exp_if, exp_we, exp_addr, exp_len);
      end
      m_addr_ready_i = 1'b1;
      settle();
      total++;
      if ({if_addr_ready_o, ls_addr_ready_o} !== (exp_if ? 2'b10 : 2'b01)) begin
         bad++;
         $display("FAIL addr_ready got=%b want=%b", {if_addr_ready_o, ls_addr_ready_o},
                  exp_if ? 2'b10 : 2'b01);
      end
      tick();
      m_addr_ready_i = 1'b0;
      if (!keep_req) begin
         if (exp_if) if_addr_valid_i = 1'b0;
         else        ls_addr_valid_i = 1'b0;
      end

      got = 0;
      ph  = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (got > int'(exp_len)) break;
         ph = toggle ? ~ph : 1'b1;
         m_r_valid_i = 1'b1;
         m_r_data_i  = base + 64'(got);
         if (exp_we) begin
            ls_w_valid_i = 1'b1;
            ls_w_data_i  = base + 64'(got);
            m_w_ready_i  = ph;
            if_r_ready_i = 1'b1;
            ls_r_ready_i = 1'b1;
            if (ph) w_q.push_back(base + 64'(got));
         end else begin
            if_r_ready_i = exp_if ? ph : 1'b1;
            ls_r_ready_i = exp_if ? 1'b1 : ph;
            if (ph) begin
               if (exp_if) if_q.push_back(base + 64'(got));
               else        ls_q.push_back(base + 64'(got));
            end
         end
         settle();
         rdy = exp_we ? ls_w_ready_o : m_r_ready_o;
         total++;
         if ({rdy, if_addr_ready_o, ls_addr_ready_o, m_if_o, m_addr_valid_o} !==
             {ph, 2'b00, exp_if, 1'b0}) begin
            bad++;
            $display("FAIL data_phase got=%b want=%b",
                     {rdy, if_addr_ready_o, ls_addr_ready_o, m_if_o, m_addr_valid_o},
                     {ph, 2'b00, exp_if, 1'b0});
         end
         if (ph) got++;
         tick();
      end
      total++;
      if (got <= int'(exp_len)) begin
         bad++;
         $display("FAIL data_timeout got=%0d want=%0d", got, int'(exp_len) + 1);
      end

      m_r_valid_i  = 1'b1;
      if_r_ready_i = 1'b1;
      ls_r_ready_i = 1'b1;
      ls_w_valid_i = 1'b1;
      m_w_ready_i  = 1'b1;
      for (int d = 0; d < drain_wait; d++) begin
         settle();
         total++;
         if ({m_addr_valid_o, if_addr_ready_o, ls_addr_ready_o, m_if_o} !== {3'b000, exp_if}) begin
            bad++;
            $display("FAIL drain_hold got=%b want=%b",
                     {m_addr_valid_o, if_addr_ready_o, ls_addr_ready_o, m_if_o}, {3'b000, exp_if});
         end
         tick();
      end
      m_addr_ready_i = 1'b1;
      settle();
      total++;
      if ({m_addr_valid_o, if_addr_ready_o, ls_addr_ready_o} !== 3'b000) begin
         bad++;
         $display("FAIL drain_exit got=%b want=000",
                  {m_addr_valid_o, if_addr_ready_o, ls_addr_ready_o});
      end
      tick();
      m_r_valid_i    = 1'b0;
      if_r_ready_i   = 1'b0;
      ls_r_ready_i   = 1'b0;
      ls_w_valid_i   = 1'b0;
      m_w_ready_i    = 1'b0;
      m_addr_ready_i = 1'b0;
      total++;
      if (if_q.size() + ls_q.size() + w_q.size() != 0) begin
         bad++;
         $display("FAIL beats_missing got=%0d want=0", if_q.size() + ls_q.size() + w_q.size());
      end
      if_q.delete();
      ls_q.delete();
      w_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      if_addr_valid_i = 1'b1;
      ls_addr_valid_i = 1'b1;
      if_r_ready_i    = 1'b1;
      ls_r_ready_i    = 1'b1;
      ls_w_valid_i    = 1'b1;
      m_addr_ready_i  = 1'b1;
      m_w_ready_i     = 1'b1;
      m_r_valid_i     = 1'b1;
      for (int i = 0; i < 2; i++) begin
         settle();
         total++;
         if ({m_addr_valid_o, if_addr_ready_o, ls_addr_ready_o, if_r_valid_o, ls_r_valid_o,
              ls_w_ready_o, m_w_valid_o, m_r_ready_o, m_if_o} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000000",
                     {m_addr_valid_o, if_addr_ready_o, ls_addr_ready_o, if_r_valid_o, ls_r_valid_o,
                      ls_w_ready_o, m_w_valid_o, m_r_ready_o, m_if_o});
         end
         tick();
      end
      clear_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ifu_read();
      int lat;
      if_addr_valid_i = 1'b1;
      if_addr_i       = 32'h8000_0000;
      if_len_i        = 8'd0;
      ls_we_i         = 1'b1;
      run_txn(1'b1, 1'b0, 32'h8000_0000, 8'd0, 64'h1234, 1'b0, 1, 1'b0, lat);
      total++;
      if (lat != 1) begin
         bad++;
         $display("FAIL ifu_latency got=%0d want=1", lat);
      end
      ls_we_i = 1'b0;
   endtask

   task automatic test_lsu_write();
      int lat;
      ls_addr_valid_i = 1'b1;
      ls_addr_i       = 32'h0000_0100;
      ls_we_i         = 1'b1;
      ls_len_i        = 8'd1;
      if_addr_valid_i = 1'b1;
      if_addr_i       = 32'h8000_0040;
      if_len_i        = 8'd0;
      run_txn(1'b0, 1'b1, 32'h0000_0100, 8'd1, 64'hAAAA_0000_0000_000A, 1'b0, 3, 1'b0, lat);
      ls_we_i = 1'b0;
      run_txn(1'b1, 1'b0, 32'h8000_0040, 8'd0, 64'h55, 1'b0, 0, 1'b0, lat);
   endtask

   task automatic test_tie();
      int lat;
      ls_addr_valid_i = 1'b1;
      ls_addr_i       = 32'h0000_0200;
      ls_we_i         = 1'b0;
      ls_len_i        = 8'd0;
      run_txn(1'b0, 1'b0, 32'h0000_0200, 8'd0, 64'h200, 1'b0, 1, 1'b0, lat);
      if_addr_valid_i = 1'b1;
      if_addr_i       = 32'h8000_0080;
      if_len_i        = 8'd0;
      ls_addr_valid_i = 1'b1;
      ls_addr_i       = 32'h0000_0208;
`ifdef YSYX_22050133_ARB_RR_EN
      run_txn(1'b1, 1'b0, 32'h8000_0080, 8'd0, 64'h300, 1'b0, 2, 1'b0, lat);
      run_txn(1'b0, 1'b0, 32'h0000_0208, 8'd0, 64'h301, 1'b0, 1, 1'b0, lat);
`else
      run_txn(1'b0, 1'b0, 32'h0000_0208, 8'd0, 64'h301, 1'b0, 2, 1'b0, lat);
      run_txn(1'b1, 1'b0, 32'h8000_0080, 8'd0, 64'h300, 1'b0, 1, 1'b0, lat);
`endif
   endtask

   task automatic test_lsu_read_toggle();
      int lat;
      ls_addr_valid_i = 1'b1;
      ls_addr_i       = 32'h0000_0300;
      ls_we_i         = 1'b0;
      ls_len_i        = 8'd3;
      run_txn(1'b0, 1'b0, 32'h0000_0300, 8'd3, 64'hBEEF_0000_0000_0010, 1'b1, 2, 1'b0, lat);
   endtask

   task automatic test_reset_mid_write();
      int lat;
      ls_addr_valid_i = 1'b1;
      ls_addr_i       = 32'h0000_0400;
      ls_we_i         = 1'b1;
      ls_len_i        = 8'd3;
      tick();
      settle();
      total++;
      if (m_addr_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL rst_wr_addr got=%b want=1", m_addr_valid_o);
      end
      m_addr_ready_i = 1'b1;
      tick();
      ls_addr_valid_i = 1'b0;
      m_addr_ready_i  = 1'b0;
      ls_w_valid_i    = 1'b1;
      ls_w_data_i     = 64'hC0DE_0001;
      m_w_ready_i     = 1'b1;
      w_q.push_back(64'hC0DE_0001);
      tick();
      ls_w_data_i = 64'hC0DE_0002;
      rst         = 1'b1;
      settle();
      total++;
      if ({m_addr_valid_o, if_addr_ready_o, ls_addr_ready_o, if_r_valid_o, ls_r_valid_o,
           ls_w_ready_o, m_w_valid_o, m_r_ready_o} !== 8'd0) begin
         bad++;
         $display("FAIL rst_async got=%b want=00000000",
                  {m_addr_valid_o, if_addr_ready_o, ls_addr_ready_o, if_r_valid_o, ls_r_valid_o,
                   ls_w_ready_o, m_w_valid_o, m_r_ready_o});
      end
      total++;
      if (w_q.size() != 0) begin
         bad++;
         $display("FAIL rst_first_beat got=%0d want=0", w_q.size());
      end
      w_q.delete();
      tick();
      clear_inputs();
      rst = 1'b0;
      if_addr_valid_i = 1'b1;
      if_addr_i       = 32'h8000_0100;
      if_len_i        = 8'd0;
      run_txn(1'b1, 1'b0, 32'h8000_0100, 8'd0, 64'h7777, 1'b0, 0, 1'b0, lat);
      total++;
      if (lat != 1) begin
         bad++;
         $display("FAIL rst_rearb_latency got=%0d want=1", lat);
      end
   endtask

   task automatic test_long_burst();
      int lat;
      ls_addr_valid_i = 1'b1;
      ls_addr_i       = 32'h0000_0500;
      ls_we_i         = 1'b0;
      ls_len_i        = 8'd15;
      if_addr_valid_i = 1'b1;
      if_addr_i       = 32'h8000_00C0;
      if_len_i        = 8'd0;
`ifdef YSYX_22050133_ARB_RR_EN
      run_txn(1'b0, 1'b0, 32'h0000_0500, 8'd15, 64'h1000, 1'b0, 1, 1'b1, lat);
      run_txn(1'b1, 1'b0, 32'h8000_00C0, 8'd0, 64'h2000, 1'b0, 1, 1'b0, lat);
      run_txn(1'b0, 1'b0, 32'h0000_0500, 8'd15, 64'h3000, 1'b0, 1, 1'b0, lat);
`else
      run_txn(1'b0, 1'b0, 32'h0000_0500, 8'd15, 64'h1000, 1'b0, 1, 1'b1, lat);
      run_txn(1'b0, 1'b0, 32'h0000_0500, 8'd15, 64'h3000, 1'b0, 1, 1'b0, lat);
      run_txn(1'b1, 1'b0, 32'h8000_00C0, 8'd0, 64'h2000, 1'b0, 1, 1'b0, lat);
`endif
   endtask

   task automatic test_max_len();
      int lat;
      ls_addr_valid_i = 1'b1;
      ls_addr_i       = 32'h0000_1000;
      ls_we_i         = 1'b0;
      ls_len_i        = 8'd255;
      run_txn(1'b0, 1'b0, 32'h0000_1000, 8'd255, 64'hF000_0000_0000_0000, 1'b0, 1, 1'b0, lat);
   endtask

   initial begin
      test_reset();
      test_ifu_read();
      test_lsu_write();
      test_tie();
      test_lsu_read_toggle();
      test_reset_mid_write();
      test_long_burst();
      test_max_len();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
